// File: rtl/sd_decimator_pkg.sv
// Shared constants and helpers for the sinc3 delta-sigma decimator.
// Sizing, saturation bounds and the bitstream-to-+/-1 mapping live here.
package sd_pkg;

  localparam int CIC_ORDER    = 3;
  localparam int SETTLE_TICKS = CIC_ORDER;

  // Bitstream mapping: 1 -> +1, 0 -> -1
  localparam int X_POS = 1;
  localparam int X_NEG = -1;

  function automatic int cic_w(input int osr_log2);
    return CIC_ORDER * osr_log2 + 2;
  endfunction

  function automatic longint sat_max(input int bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/sd_decimator_integrator.sv
// Single modulo-2**W accumulator stage of the CIC integrator chain.
// Overflow wraps by design; the comb section cancels it.
module sd_cic_integrator #(
  parameter int W = 17
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic [W-1:0] i_add,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] r_acc;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= r_acc + i_add;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/sd_decimator.sv
// 1-bit delta-sigma bitstream to BW-bit PCM: sinc3 CIC, decimate by 2**OSR_LOG2,
// scale and saturate. Optional clip_o flag is enabled with SD_DEC_CLIP_EN.
module sd_decimator
  import sd_pkg::*;
#(
  parameter int BW       = 16,
  parameter int OSR_LOG2 = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 sd_i,
  output logic signed [BW-1:0] data_o,
  output logic                 valid_o
`ifdef SD_DEC_CLIP_EN
  ,
  output logic                 clip_o
`endif
);

  localparam int W  = cic_w(OSR_LOG2);
  localparam int SH = CIC_ORDER * OSR_LOG2 - (BW - 1);
  localparam logic signed [W-1:0] SAT_HI = W'(sat_max(BW));
  localparam logic signed [W-1:0] SAT_LO = W'(sat_min(BW));

  logic [CIC_ORDER:0][W-1:0]   w_stage;
  logic [CIC_ORDER-1:0][W-1:0] r_z;
  logic [OSR_LOG2-1:0]         r_cnt;
  logic [1:0]                  r_settle;
  logic signed [BW-1:0]        r_data;
  logic                        r_valid;
  logic                        r_clip;

  logic                        w_tick;
  logic [W-1:0]                w_c1, w_c2, w_c3;
  logic signed [W-1:0]         w_sh;
  logic signed [BW-1:0]        w_y;
  logic                        w_clip;

  assign w_stage[0] = sd_i ? W'(X_POS) : W'(X_NEG);

  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_int
    sd_cic_integrator #(.W(W)) u_int (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .i_add (w_stage[g]),
      .o_acc (w_stage[g+1])
    );
  end

  // Combs run at the decimated rate on the pre-edge last integrator value
  assign w_tick = &r_cnt;
  assign w_c1   = w_stage[CIC_ORDER] - r_z[0];
  assign w_c2   = w_c1 - r_z[1];
  assign w_c3   = w_c2 - r_z[2];
  assign w_sh   = $signed(w_c3) >>> SH;

  always_comb begin
    w_y    = w_sh[BW-1:0];
    w_clip = 1'b0;
    if (w_sh > SAT_HI) begin
      w_y    = SAT_HI[BW-1:0];
      w_clip = 1'b1;
    end else if (w_sh < SAT_LO) begin
      w_y    = SAT_LO[BW-1:0];
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_z      <= '0;
      r_cnt    <= '0;
      r_settle <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_clip   <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_valid <= 1'b0;
      if (w_tick) begin
        r_z[0]  <= w_stage[CIC_ORDER];
        r_z[1]  <= w_c1;
        r_z[2]  <= w_c2;
        r_data  <= w_y;
        r_clip  <= w_clip;
        // First ticks only flush the comb delays; hold valid off until filled
        r_valid <= (r_settle == 2'(SETTLE_TICKS));
        if (r_settle != 2'(SETTLE_TICKS)) r_settle <= r_settle + 1'b1;
      end
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
`ifdef SD_DEC_CLIP_EN
  assign clip_o  = r_clip;
`endif

endmodule

// File: tb/tb_sd_decimator.sv
// Self-checking bench for sd_decimator: sinc3 convolution reference model,
// pattern table, latency/reset sequences, modulator loopback and random bits.
module tb_sd_decimator;

  localparam int BW       = 16;
  localparam int OSR_LOG2 = 5;
  localparam int R        = 1 << OSR_LOG2;
  localparam int NK       = 3 * R - 2;
  localparam int SH       = 3 * OSR_LOG2 - (BW - 1);
  localparam int HMAX     = (1 << (BW - 1)) - 1;
  localparam int HMIN     = -(1 << (BW - 1));
  localparam int XMAX     = 16384;

  logic                 clk_i = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 sd_i  = 1'b0;
  logic signed [BW-1:0] data_o;
  logic                 valid_o;
`ifdef SD_DEC_CLIP_EN
  logic                 clip_o;
`endif

  sd_decimator #(.BW(BW), .OSR_LOG2(OSR_LOG2)) dut (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .sd_i    (sd_i),
    .data_o  (data_o),
    .valid_o (valid_o)
`ifdef SD_DEC_CLIP_EN
    ,
    .clip_o  (clip_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: output at each tick is the sinc3 kernel applied to the
  // +/-1 history (zero before reset release), then shift and saturate.
  int h [NK];
  int xh [XMAX];
  int t;
  int m_data;
  bit m_valid;
  bit m_clip;

  typedef struct {
    string      name;
    logic [3:0] pat;
    int         plen;
    int         exp_data;
    bit         exp_clip;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  function automatic longint conv_at(input int tt);
    longint s = 0;
    for (int j = 0; j < NK; j++) begin
      int idx = tt - 3 - j;
      if (idx >= 1) s += longint'(h[j]) * longint'(xh[idx]);
    end
    return s;
  endfunction

  task automatic step(input bit b);
    longint y;
    int     ys;
    sd_i = b;
    @(posedge clk_i);
    if (!rst_n) begin
      t = 0; m_data = 0; m_valid = 0; m_clip = 0;
    end else begin
      t++;
      if (t < XMAX) xh[t] = b ? 1 : -1;
      m_valid = 0;
      if (t % R == 0) begin
        y      = conv_at(t) >>> SH;
        ys     = (y > HMAX) ? HMAX : (y < HMIN) ? HMIN : int'(y);
        m_data = ys;
        m_clip = (longint'(ys) != y);
        m_valid = (t / R >= 4);
      end
    end
    #1;
    check("data_o", int'(data_o), m_data);
    check("valid_o", int'(valid_o), int'(m_valid));
`ifdef SD_DEC_CLIP_EN
    if (m_valid) check("clip_o", int'(clip_o), int'(m_clip));
`endif
  endtask

  // Asserts reset away from the clock edge, holds it with random bits, releases.
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    t = 0; m_data = 0; m_valid = 0; m_clip = 0;
    check("async_rst_data", int'(data_o), 0);
    check("async_rst_valid", int'(valid_o), 0);
`ifdef SD_DEC_CLIP_EN
    check("async_rst_clip", int'(clip_o), 0);
`endif
    for (int i = 0; i < hold; i++) step(1'($urandom));
    rst_n = 1'b1;
  endtask

  task automatic run_latency(input string tag);
    int first = -1;
    int prev  = 0;
    for (int c = 1; c <= 6 * R; c++) begin
      step(1'($urandom));
      if (valid_o) begin
        if (first < 0) begin
          first = t;
          check({tag, "_first_valid"}, first, 4 * R);
        end else begin
          check({tag, "_period"}, t - prev, R);
        end
        prev = t;
      end
    end
    if (first < 0) check({tag, "_first_valid_timeout"}, -1, 4 * R);
  endtask

  initial begin
    int b2 [2*R-1];
    int acc;
    bit b;

    for (int i = 0; i < 2 * R - 1; i++) b2[i] = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) b2[i+j] += 1;
    for (int i = 0; i < NK; i++) h[i] = 0;
    for (int i = 0; i < 2 * R - 1; i++)
      for (int j = 0; j < R; j++) h[i+j] += b2[i];

    vecs[0] = '{"all_ones",  4'b0001, 1,  32767, 1'b1};
    vecs[1] = '{"all_zeros", 4'b0000, 1, -32768, 1'b0};
    vecs[2] = '{"alt_10",    4'b0001, 2,      0, 1'b0};
    vecs[3] = '{"rep_1110",  4'b0111, 4,  16384, 1'b0};
    vecs[4] = '{"rep_1000",  4'b0001, 4, -16384, 1'b0};
    vecs[5] = '{"rep_1100",  4'b0011, 4,      0, 1'b0};

    // Reset held with random input, then release latency and period
    #1;
    do_reset(8);
    run_latency("post_reset");

    foreach (vecs[v]) begin
      do_reset(2);
      for (int c = 0; c < 6 * R; c++) begin
        step(vecs[v].pat[c % vecs[v].plen]);
        if (m_valid) begin
          check(vecs[v].name, int'(data_o), vecs[v].exp_data);
`ifdef SD_DEC_CLIP_EN
          check({vecs[v].name, "_clip"}, int'(clip_o), int'(vecs[v].exp_clip));
`endif
        end
      end
    end

    // Mid-frame reset at cnt=17 discards the partial frame
    do_reset(2);
    for (int c = 0; c < 17; c++) step(1'($urandom));
    #2;
    do_reset(3);
    run_latency("mid_frame");

    // Loopback from a first-order modulator at constant 8192
    do_reset(2);
    acc = 0;
    for (int c = 0; c < 40 * R; c++) begin
      b = (acc >= 0);
      step(b);
      acc += 8192 - (b ? 32768 : -32768);
      if (m_valid) begin
        n_chk++;
        if (int'(data_o) < 8192 - 64 || int'(data_o) > 8192 + 64) begin
          n_fail++;
          $display("FAIL loopback_8192: got %0d, expected 8192 +/- 64", data_o);
        end
      end
    end

    // Random bitstream, including a biased segment
    do_reset(2);
    for (int c = 0; c < 2000; c++) step(1'($urandom));
    for (int c = 0; c < 1000; c++) step(($urandom % 8) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_decimator.md
Name: sd_decimator

Overview:
- Receive-side counterpart of the team's first-order delta-sigma DAC modulator: converts a 1-bit delta-sigma bitstream back into BW-bit signed PCM samples.
- Structure: 3rd-order CIC (sinc3) decimation filter with decimation factor R = 2**OSR_LOG2, then scaling and saturation.
- Used for loopback verification of the modulator and as the digital back end of a 1-bit ADC front end.

Parameters:
- BW, 16, output sample width (signed two's complement).
- OSR_LOG2, 5, log2 of decimation ratio R. Legal range: 3*OSR_LOG2 >= BW-1 and OSR_LOG2 <= 8.

Ports:
- clk_i  input  1  clock; one bitstream sample per cycle.
- rst_n  input  1  reset, asynchronous, active-low.
- sd_i  input  1  bitstream bit; 1 = +1, 0 = -1, same polarity as the modulator output.
- data_o  output  BW  decimated signed sample, held between updates.
- valid_o  output  1  one-cycle strobe, high for the cycle in which a new data_o is presented.

Behaviour:
- Reset: asynchronous assert, synchronous release. On assert, all of the following clear to 0:
  - integrators, comb delays, phase counter, settle counter
  - data_o, valid_o
- Reset mid-frame discards the partial frame. Counting restarts from cnt=0 on the first edge after release.
- Internal width W = 3*OSR_LOG2 + 2, all signed.
- sd_i is mapped to x = +1 or -1, sign-extended to W.
- Integrators run every cycle: i1 <= i1 + x; i2 <= i2 + i1; i3 <= i3 + i2. They use registered (pre-edge) values.
- Integrator and comb arithmetic is modulo 2**W. Wrap-around is intentional and must not saturate.
- Phase counter cnt runs 0..R-1 and wraps. A decimation tick occurs on the edge where cnt == R-1.
- On a tick:
  - c1 = i3 - z1; c2 = c1 - z2; c3 = c2 - z3.
  - z1 <= i3; z2 <= c1; z3 <= c2. i3 is the pre-edge register value.
- Scaling: y = c3 >>> (3*OSR_LOG2 - (BW-1)), arithmetic shift, then saturate to [-(2**(BW-1)), 2**(BW-1)-1].
- Full-scale gain is R**3. Example: all-ones input gives +2**(BW-1), which clips to 2**(BW-1)-1.
- Output update:
  - On a tick: data_o <= y, and valid_o <= 1 if settled, else 0.
  - Off-tick: valid_o <= 0 and data_o holds.
- Settling: the first 3 ticks after reset are suppressed. They update data_o but keep valid_o low, because the CIC has not yet filled. The settle counter saturates at 3.
- First valid_o after reset release: 4*R cycles after the first active edge. Period thereafter is exactly R cycles.
- No backpressure. The consumer must accept valid_o when it occurs.

Optional Feature:
- Macro: SD_DEC_CLIP_EN.
- Defined:
  - Adds output port clip_o (1 bit), reset value 0.
  - On each tick, clip_o <= 1 if saturation altered y, else 0. It is registered alongside data_o.
  - clip_o is meaningful only when valid_o = 1.
- Undefined: the port is absent. Saturation behaviour is identical.

Decomposition:
- Package sd_pkg holds:
  - localparam helpers: CIC_ORDER=3, function for W
  - saturation bounds as functions of BW
  - the bit-to-±1 mapping constants
- One natural sub-module: sd_cic_integrator (single W-bit modulo accumulator with async active-low reset), instantiated 3 times.
- Combs, counters and output logic stay in the top module.

Test Plan (defaults BW=16, R=32):
- Reset check: hold rst_n=0, drive sd_i randomly → data_o=0, valid_o=0 throughout; release → first valid_o exactly 128 cycles later, then every 32 cycles.
- Constant sd_i=1 → steady data_o=32767 (clipped from 32768); constant sd_i=0 → data_o=-32768; with SD_DEC_CLIP_EN, clip_o=1 for sd_i=1 only.
- Alternating 1,0,1,0 → data_o=0 on every valid sample after settling.
- Repeating 1,1,1,0 → data_o=16384; repeating 1,0,0,0 → data_o=-16384.
- Loopback: modulator driven with constant 8192 feeding sd_i → data_o within ±64 of 8192 after settling. A long run (>2**17 cycles) produces no drift, confirming integrator wrap is benign.
- Assert rst_n low mid-frame (cnt≈17), release → counters restart, valid_o suppressed for 3 ticks, first valid 128 cycles after release.
